// File: rtl/elevator_ctrl_n_if.sv
// Elevator controller bus interface.
// Groups the button/sensor front-end inputs and the motor/door/status outputs
// of elevator_ctrl_n.
//   master : front-end side (drives buttons/sensors, observes car status)
//   slave  : controller side
// Signals:
//   Dsensor, Dopen, Dclose   door obstruction / open / close requests
//   car_call, hall_up, hall_dn  one bit per floor call buttons
//   up, down, door_open      registered car motion / door state
//   floor                    current floor index
//   car_pend, up_pend, dn_pend  latched (pending) calls
interface elevator_ctrl_n_if #(
  parameter int unsigned NUM_FLOORS = 4,
  parameter int unsigned FLOOR_W    = 2
);
  logic                  Dsensor;
  logic                  Dopen;
  logic                  Dclose;
  logic [NUM_FLOORS-1:0] car_call;
  logic [NUM_FLOORS-1:0] hall_up;
  logic [NUM_FLOORS-1:0] hall_dn;
  logic                  up;
  logic                  down;
  logic                  door_open;
  logic [FLOOR_W-1:0]    floor;
  logic [NUM_FLOORS-1:0] car_pend;
  logic [NUM_FLOORS-1:0] up_pend;
  logic [NUM_FLOORS-1:0] dn_pend;

  modport master (
    output Dsensor, Dopen, Dclose, car_call, hall_up, hall_dn,
    input  up, down, door_open, floor, car_pend, up_pend, dn_pend
  );

  modport slave (
    input  Dsensor, Dopen, Dclose, car_call, hall_up, hall_dn,
    output up, down, door_open, floor, car_pend, up_pend, dn_pend
  );
endinterface

// File: rtl/elevator_ctrl_n.sv
// N-floor single-car elevator controller with collective (SCAN) dispatch.
// Car and hall calls latch into sticky pending registers; the car keeps its
// travel direction while calls remain ahead, runs a timed door-open phase and
// a timed floor-to-floor travel phase.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    elevator_ctrl_n_if.slave (buttons/sensors in, motion/door/status out)
module elevator_ctrl_n #(
  parameter int unsigned NUM_FLOORS   = 4,
  parameter int unsigned FLOOR_W      = 2,
  parameter int unsigned DOOR_TICKS   = 3,
  parameter int unsigned TRAVEL_TICKS = 4
) (
  input logic              clk,
  input logic              reset,
  elevator_ctrl_n_if.slave bus
);

  localparam int unsigned DW = $clog2(DOOR_TICKS + 1);
  localparam int unsigned TW = $clog2(TRAVEL_TICKS + 1);
  localparam logic [FLOOR_W-1:0]    TOP       = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [DW-1:0]         DOOR_MAX  = DW'(DOOR_TICKS);
  localparam logic [TW-1:0]         TRAV_LAST = TW'(TRAVEL_TICKS - 1);
  localparam logic [NUM_FLOORS-1:0] UP_MASK   = {1'b0, {(NUM_FLOORS-1){1'b1}}};
  localparam logic [NUM_FLOORS-1:0] DN_MASK   = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, OPEN, MOVE_UP, MOVE_DN} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;

  state_t                state_q, state_d;
  dir_t                  dir_q, dir_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic [DW-1:0]         door_tmr_q, door_tmr_d;
  logic [TW-1:0]         trav_tmr_q, trav_tmr_d;
  logic [NUM_FLOORS-1:0] car_pend_q, car_pend_d;
  logic [NUM_FLOORS-1:0] up_pend_q, up_pend_d;
  logic [NUM_FLOORS-1:0] dn_pend_q, dn_pend_d;
  logic                  mv_up_q, mv_up_d;
  logic                  mv_dn_q, mv_dn_d;
  logic                  door_open_q, door_open_d;

  logic [NUM_FLOORS-1:0] up_in, dn_in;
  logic [NUM_FLOORS-1:0] car_l, up_l, dn_l, all_l;
  logic [FLOOR_W-1:0]    nf;
  logic                  open_entry, here, press_here, reload;
  logic                  going_up, ahead, behind, with_dir, against, end_floor;
  logic                  above_now, below_now;
  logic [DW-1:0]         door_inc;

  function automatic logic any_above(input logic [NUM_FLOORS-1:0] v,
                                     input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++)
      if (v[i] && (i > 32'(f))) r = 1'b1;
    return r;
  endfunction

  function automatic logic any_below(input logic [NUM_FLOORS-1:0] v,
                                     input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++)
      if (v[i] && (i < 32'(f))) r = 1'b1;
    return r;
  endfunction

  always_comb begin
    up_in       = bus.hall_up & UP_MASK;
    dn_in       = bus.hall_dn & DN_MASK;
    car_l       = car_pend_q | bus.car_call;
    up_l        = up_pend_q | up_in;
    dn_l        = dn_pend_q | dn_in;
    all_l       = car_l | up_l | dn_l;

    state_d     = state_q;
    dir_d       = dir_q;
    floor_d     = floor_q;
    door_tmr_d  = door_tmr_q;
    trav_tmr_d  = trav_tmr_q;
    car_pend_d  = car_l;
    up_pend_d   = up_l;
    dn_pend_d   = dn_l;
    nf          = floor_q;
    open_entry  = 1'b0;
    here        = 1'b0;
    press_here  = 1'b0;
    reload      = 1'b0;
    going_up    = 1'b0;
    ahead       = 1'b0;
    behind      = 1'b0;
    with_dir    = 1'b0;
    against     = 1'b0;
    end_floor   = 1'b0;
    above_now   = any_above(all_l, floor_q);
    below_now   = any_below(all_l, floor_q);
    door_inc    = (door_tmr_q == DOOR_MAX) ? DOOR_MAX : door_tmr_q + DW'(1);

    case (state_q)
      IDLE: begin
        here = car_l[floor_q]
             | ((dir_q != DIR_DN) & up_l[floor_q])
             | ((dir_q != DIR_UP) & dn_l[floor_q]);
        if (here || bus.Dopen) begin
          state_d    = OPEN;
          door_tmr_d = '0;
          open_entry = 1'b1;
        end else if (above_now && (dir_q != DIR_DN || !below_now)) begin
          state_d    = MOVE_UP;
          dir_d      = DIR_UP;
          trav_tmr_d = '0;
        end else if (below_now) begin
          state_d    = MOVE_DN;
          dir_d      = DIR_DN;
          trav_tmr_d = '0;
        end else begin
          dir_d      = DIR_NONE;
        end
      end

      OPEN: begin
        // A fresh press of an already-served button only holds the door;
        // it must not re-latch the call just cleared.
        press_here = bus.car_call[floor_q]
                   | ((dir_q != DIR_DN) & up_in[floor_q])
                   | ((dir_q != DIR_UP) & dn_in[floor_q]);
        car_pend_d[floor_q] = car_pend_q[floor_q];
        if (dir_q != DIR_DN) up_pend_d[floor_q] = up_pend_q[floor_q];
        if (dir_q != DIR_UP) dn_pend_d[floor_q] = dn_pend_q[floor_q];

        reload = bus.Dsensor | bus.Dopen | press_here;
        if (reload)          door_tmr_d = '0;
        else if (bus.Dclose) door_tmr_d = DOOR_MAX;
        else                 door_tmr_d = door_inc;

        if (!reload && door_tmr_d == DOOR_MAX) state_d = IDLE;
      end

      MOVE_UP, MOVE_DN: begin
        going_up = (state_q == MOVE_UP);
        if (trav_tmr_q == TRAV_LAST) begin
          trav_tmr_d = '0;
          nf         = going_up ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
          floor_d    = nf;
          ahead      = going_up ? any_above(all_l, nf) : any_below(all_l, nf);
          behind     = going_up ? any_below(all_l, nf) : any_above(all_l, nf);
          with_dir   = going_up ? up_l[nf] : dn_l[nf];
          against    = going_up ? dn_l[nf] : up_l[nf];
          end_floor  = going_up ? (nf == TOP) : (nf == '0);
          if (car_l[nf] || with_dir || (against && !ahead) || end_floor) begin
            state_d    = OPEN;
            door_tmr_d = '0;
            open_entry = 1'b1;
            // An opposite-direction hall call at the stop floor is treated
            // as a call behind, so the reversal serves it here and now.
            if (!ahead) begin
              if (behind || (against && !with_dir))
                dir_d = going_up ? DIR_DN : DIR_UP;
              else
                dir_d = DIR_NONE;
            end
          end
        end else begin
          trav_tmr_d = trav_tmr_q + TW'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // Served calls are cleared against the direction the car leaves with.
    if (open_entry) begin
      car_pend_d[nf] = 1'b0;
      if (dir_d == DIR_NONE && up_pend_d[nf] && dn_pend_d[nf]) begin
        up_pend_d[nf] = 1'b0;
      end else begin
        if (dir_d != DIR_DN) up_pend_d[nf] = 1'b0;
        if (dir_d != DIR_UP) dn_pend_d[nf] = 1'b0;
      end
    end

    mv_up_d     = (state_d == MOVE_UP);
    mv_dn_d     = (state_d == MOVE_DN);
    door_open_d = (state_d == OPEN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dir_q       <= DIR_NONE;
      floor_q     <= '0;
      door_tmr_q  <= '0;
      trav_tmr_q  <= '0;
      car_pend_q  <= '0;
      up_pend_q   <= '0;
      dn_pend_q   <= '0;
      mv_up_q     <= 1'b0;
      mv_dn_q     <= 1'b0;
      door_open_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      floor_q     <= floor_d;
      door_tmr_q  <= door_tmr_d;
      trav_tmr_q  <= trav_tmr_d;
      car_pend_q  <= car_pend_d;
      up_pend_q   <= up_pend_d;
      dn_pend_q   <= dn_pend_d;
      mv_up_q     <= mv_up_d;
      mv_dn_q     <= mv_dn_d;
      door_open_q <= door_open_d;
    end
  end

  assign bus.up        = mv_up_q;
  assign bus.down      = mv_dn_q;
  assign bus.door_open = door_open_q;
  assign bus.floor     = floor_q;
  assign bus.car_pend  = car_pend_q;
  assign bus.up_pend   = up_pend_q;
  assign bus.dn_pend   = dn_pend_q;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Directed testbench for elevator_ctrl_n (4 floors, 3 door ticks, 2 travel ticks).
module tb_elevator_ctrl_n;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  elevator_ctrl_n_if #(.NUM_FLOORS(4), .FLOOR_W(2)) bus ();

  elevator_ctrl_n #(
    .NUM_FLOORS   (4),
    .FLOOR_W      (2),
    .DOOR_TICKS   (3),
    .TRAVEL_TICKS (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {up, down, door_open, floor[1:0], car_pend[3:0], up_pend[3:0], dn_pend[3:0]}
  typedef struct packed {
    logic        sens;
    logic        dopen;
    logic        dclose;
    logic [3:0]  car;
    logic [3:0]  hup;
    logic [3:0]  hdn;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl[25];

  function automatic logic [16:0] ex(input logic u, input logic d, input logic o,
                                     input logic [1:0] f, input logic [3:0] c,
                                     input logic [3:0] hu, input logic [3:0] hd);
    return {u, d, o, f, c, hu, hd};
  endfunction

  function automatic vec_t mk(input logic [3:0] car, input logic [3:0] hup,
                              input logic [3:0] hdn, input logic dopen,
                              input logic [16:0] e);
    vec_t v;
    v.sens = 1'b0; v.dopen = dopen; v.dclose = 1'b0;
    v.car = car; v.hup = hup; v.hdn = hdn; v.exp = e;
    return v;
  endfunction

  function automatic logic [16:0] outs();
    return {bus.up, bus.down, bus.door_open, bus.floor,
            bus.car_pend, bus.up_pend, bus.dn_pend};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Dsensor = 1'b0; bus.Dopen = 1'b0; bus.Dclose = 1'b0;
    bus.car_call = '0; bus.hall_up = '0; bus.hall_dn = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    check("reset_outs", 32'(outs()), 32'(ex(0, 0, 0, 2'd0, 4'h0, 4'h0, 4'h0)));
    reset = 1'b0;
  endtask

  task automatic wait_door(input string name, input int budget);
    int n;
    n = 0;
    while (!bus.door_open && n < budget) begin tick(); n++; end
    n_cmp++;
    if (!bus.door_open) begin
      n_bad++;
      $display("FAIL %s: door_open=0 after %0d cycles, expected 1", name, budget);
    end
  endtask

  task automatic wait_close(input string name, input int budget);
    int n;
    n = 0;
    while (bus.door_open && n < budget) begin tick(); n++; end
    n_cmp++;
    if (bus.door_open) begin
      n_bad++;
      $display("FAIL %s: door_open=1 after %0d cycles, expected 0", name, budget);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    idle_inputs();

    // One row per clock edge: inputs held across the edge, outputs after it.
    // Rows 0-8: car call to floor 2 from floor 0, then door cycle.
    tbl[0]  = mk(4'b0100, 4'h0, 4'h0, 0, ex(1, 0, 0, 2'd0, 4'b0100, 4'h0, 4'h0));
    tbl[1]  = mk(4'h0, 4'h0, 4'h0, 0, ex(1, 0, 0, 2'd0, 4'b0100, 4'h0, 4'h0));
    tbl[2]  = mk(4'h0, 4'h0, 4'h0, 0, ex(1, 0, 0, 2'd1, 4'b0100, 4'h0, 4'h0));
    tbl[3]  = mk(4'h0, 4'h0, 4'h0, 0, ex(1, 0, 0, 2'd1, 4'b0100, 4'h0, 4'h0));
    tbl[4]  = mk(4'h0, 4'h0, 4'h0, 0, ex(0, 0, 1, 2'd2, 4'h0, 4'h0, 4'h0));
    tbl[5]  = mk(4'h0, 4'h0, 4'h0, 0, ex(0, 0, 1, 2'd2, 4'h0, 4'h0, 4'h0));
    tbl[6]  = mk(4'h0, 4'h0, 4'h0, 0, ex(0, 0, 1, 2'd2, 4'h0, 4'h0, 4'h0));
    tbl[7]  = mk(4'h0, 4'h0, 4'h0, 0, ex(0, 0, 0, 2'd2, 4'h0, 4'h0, 4'h0));
    tbl[8]  = mk(4'h0, 4'h0, 4'h0, 0, ex(0, 0, 0, 2'd2, 4'h0, 4'h0, 4'h0));
    // Rows 9-12: Dopen while idle -> door open exactly 3 cycles.
    tbl[9]  = mk(4'h0, 4'h0, 4'h0, 1, ex(0, 0, 1, 2'd2, 4'h0, 4'h0, 4'h0));
    tbl[10] = mk(4'h0, 4'h0, 4'h0, 0, ex(0, 0, 1, 2'd2, 4'h0, 4'h0, 4'h0));
    tbl[11] = mk(4'h0, 4'h0, 4'h0, 0, ex(0, 0, 1, 2'd2, 4'h0, 4'h0, 4'h0));
    tbl[12] = mk(4'h0, 4'h0, 4'h0, 0, ex(0, 0, 0, 2'd2, 4'h0, 4'h0, 4'h0));
    // Row 13: ignored hall bits never latch.
    tbl[13] = mk(4'h0, 4'b1000, 4'b0001, 0, ex(0, 0, 0, 2'd2, 4'h0, 4'h0, 4'h0));
    // Rows 14-24: car call 0 + hall up 1 together; pass floor 1 going down,
    // turn at 0, come back up for the hall-up call.
    tbl[14] = mk(4'b0001, 4'b0010, 4'h0, 0, ex(0, 1, 0, 2'd2, 4'b0001, 4'b0010, 4'h0));
    tbl[15] = mk(4'h0, 4'h0, 4'h0, 0, ex(0, 1, 0, 2'd2, 4'b0001, 4'b0010, 4'h0));
    tbl[16] = mk(4'h0, 4'h0, 4'h0, 0, ex(0, 1, 0, 2'd1, 4'b0001, 4'b0010, 4'h0));
    tbl[17] = mk(4'h0, 4'h0, 4'h0, 0, ex(0, 1, 0, 2'd1, 4'b0001, 4'b0010, 4'h0));
    tbl[18] = mk(4'h0, 4'h0, 4'h0, 0, ex(0, 0, 1, 2'd0, 4'h0, 4'b0010, 4'h0));
    tbl[19] = mk(4'h0, 4'h0, 4'h0, 0, ex(0, 0, 1, 2'd0, 4'h0, 4'b0010, 4'h0));
    tbl[20] = mk(4'h0, 4'h0, 4'h0, 0, ex(0, 0, 1, 2'd0, 4'h0, 4'b0010, 4'h0));
    tbl[21] = mk(4'h0, 4'h0, 4'h0, 0, ex(0, 0, 0, 2'd0, 4'h0, 4'b0010, 4'h0));
    tbl[22] = mk(4'h0, 4'h0, 4'h0, 0, ex(1, 0, 0, 2'd0, 4'h0, 4'b0010, 4'h0));
    tbl[23] = mk(4'h0, 4'h0, 4'h0, 0, ex(1, 0, 0, 2'd0, 4'h0, 4'b0010, 4'h0));
    tbl[24] = mk(4'h0, 4'h0, 4'h0, 0, ex(0, 0, 1, 2'd1, 4'h0, 4'h0, 4'h0));

    do_reset();
    for (int i = 0; i < 25; i++) begin
      bus.Dsensor  = tbl[i].sens;
      bus.Dopen    = tbl[i].dopen;
      bus.Dclose   = tbl[i].dclose;
      bus.car_call = tbl[i].car;
      bus.hall_up  = tbl[i].hup;
      bus.hall_dn  = tbl[i].hdn;
      tick();
      check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end
    idle_inputs();

    // Hall down at top plus car call at 1: stop at 1, continue to 3.
    do_reset();
    bus.car_call = 4'b0010; bus.hall_dn = 4'b1000;
    tick();
    idle_inputs();
    check("t2_latch", 32'(outs()), 32'(ex(1, 0, 0, 2'd0, 4'b0010, 4'h0, 4'b1000)));
    wait_door("t2_open1", 20);
    check("t2_floor1", 32'(outs()), 32'(ex(0, 0, 1, 2'd1, 4'h0, 4'h0, 4'b1000)));
    wait_close("t2_close1", 10);
    wait_door("t2_open3", 20);
    check("t2_floor3", 32'(outs()), 32'(ex(0, 0, 1, 2'd3, 4'h0, 4'h0, 4'h0)));
    repeat (8) tick();
    check("t2_rest", 32'(outs()), 32'(ex(0, 0, 0, 2'd3, 4'h0, 4'h0, 4'h0)));

    // Door held by obstruction; Dclose ignored while obstructed.
    do_reset();
    bus.car_call = 4'b0100;
    tick();
    idle_inputs();
    wait_door("t3_open", 20);
    check("t3_floor", 32'(bus.floor), 32'd2);
    bus.Dsensor = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.Dclose = (i % 2 == 1);
      tick();
      check($sformatf("t3_hold%0d", i), 32'(bus.door_open), 32'd1);
    end
    bus.Dsensor = 1'b0; bus.Dclose = 1'b0;
    tick(); check("t3_rel1", 32'(bus.door_open), 32'd1);
    tick(); check("t3_rel2", 32'(bus.door_open), 32'd1);
    tick(); check("t3_rel3", 32'(bus.door_open), 32'd0);
    bus.Dopen = 1'b1;
    tick();
    bus.Dopen = 1'b0;
    check("t3_reopen", 32'(bus.door_open), 32'd1);
    bus.Dclose = 1'b1;
    tick();
    bus.Dclose = 1'b0;
    check("t3_dclose", 32'(bus.door_open), 32'd0);

    // Opposite hall call passed on the way up, served after reversal.
    do_reset();
    bus.car_call = 4'b1000;
    tick();
    idle_inputs();
    bus.hall_dn = 4'b0010;
    tick();
    idle_inputs();
    check("t4_latch", 32'(outs()), 32'(ex(1, 0, 0, 2'd0, 4'b1000, 4'h0, 4'b0010)));
    tick();
    check("t4_pass1", 32'(outs()), 32'(ex(1, 0, 0, 2'd1, 4'b1000, 4'h0, 4'b0010)));
    wait_door("t4_open3", 20);
    check("t4_floor3", 32'(outs()), 32'(ex(0, 0, 1, 2'd3, 4'h0, 4'h0, 4'b0010)));
    repeat (4) tick();
    check("t4_down", 32'(outs()), 32'(ex(0, 1, 0, 2'd3, 4'h0, 4'h0, 4'b0010)));
    wait_door("t4_open1", 20);
    check("t4_floor1", 32'(outs()), 32'(ex(0, 0, 1, 2'd1, 4'h0, 4'h0, 4'h0)));

    // Asynchronous reset mid-travel, then ignored hall bits.
    do_reset();
    bus.car_call = 4'b1000;
    tick();
    idle_inputs();
    repeat (4) tick();
    check("t5_pre", 32'(outs()), 32'(ex(1, 0, 0, 2'd2, 4'b1000, 4'h0, 4'h0)));
    bus.car_call = 4'b0001;
    tick();
    idle_inputs();
    check("t5_pend", 32'(bus.car_pend), 32'(4'b1001));
    #2 reset = 1'b1;
    #1 check("t5_async", 32'(outs()), 32'(ex(0, 0, 0, 2'd0, 4'h0, 4'h0, 4'h0)));
    tick();
    reset = 1'b0;
    bus.hall_up = 4'b1000; bus.hall_dn = 4'b0001;
    tick();
    tick();
    idle_inputs();
    check("t5_ignored", 32'(outs()), 32'(ex(0, 0, 0, 2'd0, 4'h0, 4'h0, 4'h0)));

    // Dopen at floor 0 while idle.
    bus.Dopen = 1'b1;
    tick();
    bus.Dopen = 1'b0;
    check("t6_open0", 32'(outs()), 32'(ex(0, 0, 1, 2'd0, 4'h0, 4'h0, 4'h0)));
    tick();
    check("t6_open1", 32'(outs()), 32'(ex(0, 0, 1, 2'd0, 4'h0, 4'h0, 4'h0)));
    tick();
    check("t6_open2", 32'(outs()), 32'(ex(0, 0, 1, 2'd0, 4'h0, 4'h0, 4'h0)));
    tick();
    check("t6_closed", 32'(outs()), 32'(ex(0, 0, 0, 2'd0, 4'h0, 4'h0, 4'h0)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/elevator_ctrl_n.md
Name: elevator_ctrl_n

Overview:
Parametrised N-floor single-car elevator controller, the successor to the fixed 4-floor controller. It latches car and hall calls into sticky pending registers and uses collective (SCAN) dispatch: the car keeps its travel direction while calls remain ahead of it. It runs timed door-open and floor-to-floor travel phases. It sits between the button/sensor front-end and the motor/door drivers.

Parameters:
NUM_FLOORS, 4, number of floors (≥2); floor 0 is the bottom floor.
FLOOR_W, 2, width of floor index; must satisfy 2^FLOOR_W ≥ NUM_FLOORS.
DOOR_TICKS, 3, cycles the door stays open with no hold/reopen event (≥1).
TRAVEL_TICKS, 4, cycles per one-floor move (≥1).

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  asynchronous, active-high reset
Dsensor  in  1  doorway obstruction; holds the door open
Dopen  in  1  door-open request (inside car)
Dclose  in  1  door-close request (inside car)
car_call  in  NUM_FLOORS  floor buttons inside the car, one bit per floor
hall_up  in  NUM_FLOORS  hall up buttons; bit NUM_FLOORS-1 ignored
hall_dn  in  NUM_FLOORS  hall down buttons; bit 0 ignored
up  out  1  car moving up
down  out  1  car moving down
door_open  out  1  door open
floor  out  FLOOR_W  current floor index
car_pend  out  NUM_FLOORS  latched car calls
up_pend  out  NUM_FLOORS  latched hall-up calls
dn_pend  out  NUM_FLOORS  latched hall-down calls

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, dir=NONE, floor=0.
  - up, down and door_open = 0; all pend registers = 0; timers = 0.
- Call latching:
  - Each input bit held high at a rising edge sets its pend bit.
  - A pend bit stays set until served.
  - Ignored bits (hall_up top, hall_dn bottom) never latch.
- States: IDLE, OPEN, MOVE_UP, MOVE_DN. Outputs are registered:
  - up=(state==MOVE_UP), down=(state==MOVE_DN), door_open=(state==OPEN).
- "Above"/"below" means any pend bit at an index strictly greater/less than floor.
- IDLE:
  - Call at current floor (car_pend, or up_pend/dn_pend matching dir, or either hall bit when dir=NONE), or Dopen=1: go OPEN, door timer=0.
  - Else if calls above and (dir≠DN or no calls below): go MOVE_UP, dir=UP, travel timer=0.
  - Else if calls below: go MOVE_DN, dir=DN.
  - Else stay IDLE, dir=NONE.
- OPEN:
  - Served bits cleared on entry:
    - car_pend[floor] always.
    - up_pend[floor] if dir∈{UP,NONE}.
    - dn_pend[floor] if dir∈{DN,NONE}.
    - If dir=NONE and both hall bits are set, dn_pend is kept.
  - Door timer increments each cycle, saturating at DOOR_TICKS.
  - These reload the timer to 0: Dopen, Dsensor, or a new press of a served bit at this floor. Such a press is not latched.
  - Dclose with Dsensor=0 sets the timer to DOOR_TICKS.
  - Door closes (next state IDLE) when timer==DOOR_TICKS and Dsensor=0. Dsensor always wins over Dclose.
- MOVE_UP / MOVE_DN:
  - Travel timer counts 0..TRAVEL_TICKS-1.
  - On the terminal count, floor ±1 and the timer resets.
  - Stop (next state OPEN) at the new floor if any of:
    - car_pend at that floor;
    - hall pend in the travel direction;
    - hall pend opposite to travel with no calls further ahead;
    - the new floor is 0 or NUM_FLOORS-1.
  - Otherwise continue moving.
  - On a stop with no calls further ahead, dir flips if calls exist behind, else dir=NONE.
  - Floor never leaves 0..NUM_FLOORS-1.
  - Dopen and Dclose are ignored while moving.
- Simultaneous events:
  - New calls at other floors latch in any state.
  - A call at the current floor arriving in the same cycle as the IDLE→MOVE decision is served at the next visit. Direction is not reversed mid-travel.
- Multiple inputs in one cycle are all latched; dispatch uses the pend state after latching.

Test Plan:
(All with NUM_FLOORS=4, DOOR_TICKS=3, TRAVEL_TICKS=2.)
1. Reset, then pulse car_call[2] at floor 0 → up=1; floor=1 two cycles after up rises, floor=2 at four. On that edge door_open=1, up=0, car_pend=0. Door closes 3 cycles later; state IDLE, dir=NONE.
2. At floor 0 pulse hall_dn[3] and car_call[1] → stop at floor 1 (door opens, car_pend[1] clears). Continue up, stop at 3, dn_pend[3] cleared, dir=DN.
3. Door open at floor 2, hold Dsensor=1 for 10 cycles → door_open stays 1. Release → closes exactly 3 cycles later. Dclose during the hold has no effect.
4. Moving up from 0 with car_call[3] pending, press hall_dn[1] at floor 1 → no stop at 1. Car reaches 3, then reverses, serves floor 1; dn_pend[1] cleared.
5. Assert reset mid-travel (floor=2, up=1) → immediately floor=0, up=0, all pend=0. hall_up[3] and hall_dn[0] presses never set a pend bit.
6. Idle at floor 0, pulse Dopen → door_open=1 for 3 cycles, no movement.
